score_palette_lut: RTL and testbench

Banked, writable palette lookup for the score-digit sprites. It replaces the per-digit constant colour tables with one RAM-backed unit holding NUM_BANKS palettes (one per digit glyph). It adds run-time palette writes, a brightness fade, a frame-synchronous flash (invert), and a transparency flag. It sits between the sprite ROM index output and the VGA colour mux, and uses a fixed 2-cycle pipeline with no stalls.

---
 rtl/score_palette_pkg.sv | 31 +++
 rtl/palette_ram.sv | 55 +++++
 rtl/score_palette_lut.sv | 133 +++++++++++++
 tb/tb_score_palette_lut.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/score_palette_pkg.sv
// Shared types and helpers for the score-digit palette lookup.
// Parameter defaults live here so the top and the bench agree on them.
package score_palette_pkg;

  localparam int IDX_W_DEF        = 4;
  localparam int CH_W_DEF         = 4;
  localparam int NUM_BANKS_DEF    = 10;
  localparam int BANK_W_DEF       = 4;
  localparam int FLASH_FRAMES_DEF = 16;
  localparam int TRANSP_IDX_DEF   = 0;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  typedef enum logic {
    PH_NORMAL = 1'b0,
    PH_INVERT = 1'b1
  } flash_phase_e;

  // (c * (bright+1)) >> ch_w, no rounding; handles channel widths up to 8 bits.
  function automatic logic [7:0] fade(input logic [7:0] c, input logic [7:0] bright,
                                      input int ch_w = CH_W_DEF);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, bright} + 17'd1);
    return 8'(p >> ch_w);
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Banked palette storage: one write port, one registered read-first read port.
// Out-of-range banks drop writes and read as black.
module palette_ram #(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 10,
  parameter int BANK_W    = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic [BANK_W-1:0]   rd_bank,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [3*CH_W-1:0]   rd_data_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [3*CH_W-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [3*CH_W-1:0] mem_d [NUM_BANKS][DEPTH];
  logic [3*CH_W-1:0] rd_q;
  logic [3*CH_W-1:0] rd_d;

  // Read samples mem_q, so a same-cycle write to the same entry is not seen yet.
  always_comb begin
    mem_d = mem_q;
    rd_d  = '0;
    if (wr_en && (32'(wr_bank) < NUM_BANKS)) begin
      mem_d[wr_bank][wr_idx] = wr_data;
    end
    if (32'(rd_bank) < NUM_BANKS) begin
      rd_d = mem_q[rd_bank][rd_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/score_palette_lut.sv
// Score-digit palette lookup: 2-stage pipeline (RAM read, then invert/fade),
// plus the frame-synchronous flash FSM and transparency flag.
module score_palette_lut
  import score_palette_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEF,
  parameter int CH_W         = CH_W_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int BANK_W       = BANK_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int TRANSP_IDX   = TRANSP_IDX_DEF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                pix_valid_i,
  input  logic [BANK_W-1:0]   pix_bank_i,
  input  logic [IDX_W-1:0]    pix_idx_i,
  input  logic [CH_W-1:0]     bright_i,
  input  logic                flash_en_i,
  input  logic                transp_en_i,
  input  logic                frame_tick_i,
  output logic                pix_valid_o,
  output logic [CH_W-1:0]     red_o,
  output logic [CH_W-1:0]     green_o,
  output logic [CH_W-1:0]     blue_o,
  output logic                pix_transp_o,
  output logic                flash_phase_o
);

  logic [3*CH_W-1:0] rd_data;

  palette_ram #(
    .IDX_W     (IDX_W),
    .CH_W      (CH_W),
    .NUM_BANKS (NUM_BANKS),
    .BANK_W    (BANK_W)
  ) u_ram (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_bank   (pix_bank_i),
    .rd_idx    (pix_idx_i),
    .rd_data_o (rd_data)
  );

  logic              valid_s1_q, valid_s1_d;
  logic              transp_s1_q, transp_s1_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   red_q, red_d;
  logic [CH_W-1:0]   green_q, green_d;
  logic [CH_W-1:0]   blue_q, blue_d;
  logic              transp_q, transp_d;
  flash_phase_e      phase_q, phase_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [CH_W-1:0]   ch_r, ch_g, ch_b;

  always_comb begin
    valid_s1_d  = pix_valid_i;
    transp_s1_d = (pix_idx_i == IDX_W'(TRANSP_IDX));

    ch_r = rd_data[3*CH_W-1:2*CH_W];
    ch_g = rd_data[2*CH_W-1:CH_W];
    ch_b = rd_data[CH_W-1:0];
    if (phase_q == PH_INVERT) begin
      ch_r = ~ch_r;
      ch_g = ~ch_g;
      ch_b = ~ch_b;
    end

    valid_d  = valid_s1_q;
    red_d    = CH_W'(fade(8'(ch_r), 8'(bright_i), CH_W));
    green_d  = CH_W'(fade(8'(ch_g), 8'(bright_i), CH_W));
    blue_d   = CH_W'(fade(8'(ch_b), 8'(bright_i), CH_W));
    transp_d = transp_s1_q & transp_en_i;
  end

  // Flash FSM: phase toggles every FLASH_FRAMES ticks while enabled, else parked.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!flash_en_i) begin
      cnt_d   = '0;
      phase_d = PH_NORMAL;
    end else if (frame_tick_i) begin
      if (cnt_q == 8'(FLASH_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == PH_NORMAL) ? PH_INVERT : PH_NORMAL;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_s1_q  <= 1'b0;
      transp_s1_q <= 1'b0;
      valid_q     <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      transp_q    <= 1'b0;
      phase_q     <= PH_NORMAL;
      cnt_q       <= '0;
    end else begin
      valid_s1_q  <= valid_s1_d;
      transp_s1_q <= transp_s1_d;
      valid_q     <= valid_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      transp_q    <= transp_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pix_valid_o   = valid_q;
  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign pix_transp_o  = transp_q;
  assign flash_phase_o = (phase_q == PH_INVERT);

endmodule

// File: tb/tb_score_palette_lut.sv
// Scoreboard bench for score_palette_lut: directed requests push expected
// colour/transparency; a negedge monitor pops and compares on pix_valid_o.
module tb_score_palette_lut;
  import score_palette_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_bank = '0;
  logic [3:0]  wr_idx = '0;
  logic [11:0] wr_data = '0;
  logic        pix_valid_i = 1'b0;
  logic [3:0]  pix_bank_i = '0;
  logic [3:0]  pix_idx_i = '0;
  logic [3:0]  bright_i = 4'hF;
  logic        flash_en_i = 1'b0;
  logic        transp_en_i = 1'b0;
  logic        frame_tick_i = 1'b0;
  logic        pix_valid_o;
  logic [3:0]  red_o, green_o, blue_o;
  logic        pix_transp_o;
  logic        flash_phase_o;

  score_palette_lut #(
    .IDX_W(4), .CH_W(4), .NUM_BANKS(10), .BANK_W(4), .FLASH_FRAMES(2), .TRANSP_IDX(0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
    .pix_valid_i(pix_valid_i), .pix_bank_i(pix_bank_i), .pix_idx_i(pix_idx_i),
    .bright_i(bright_i), .flash_en_i(flash_en_i), .transp_en_i(transp_en_i),
    .frame_tick_i(frame_tick_i),
    .pix_valid_o(pix_valid_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .pix_transp_o(pix_transp_o), .flash_phase_o(flash_phase_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string nm;
    rgb_t  c;
    logic  tr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_push = 0;
  int   n_pop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && pix_valid_o) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_pop++;
        check({e.nm, "_rgb"}, {20'd0, red_o, green_o, blue_o}, {20'd0, e.c});
        check({e.nm, "_transp"}, {31'd0, pix_transp_o}, {31'd0, e.tr});
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] b, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_idx = i; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic req(input string nm, input logic [3:0] b, input logic [3:0] i,
                     input logic [11:0] c, input logic tr);
    exp_t e;
    e.nm = nm; e.c = rgb_t'(c); e.tr = tr;
    pix_valid_i = 1'b1; pix_bank_i = b; pix_idx_i = i;
    q.push_back(e);
    n_push++;
    tick();
    pix_valid_i = 1'b0;
  endtask

  task automatic outs_zero(input string nm);
    check({nm, "_valid"}, {31'd0, pix_valid_o}, 32'd0);
    check({nm, "_rgb"}, {20'd0, red_o, green_o, blue_o}, 32'd0);
    check({nm, "_transp"}, {31'd0, pix_transp_o}, 32'd0);
    check({nm, "_phase"}, {31'd0, flash_phase_o}, 32'd0);
  endtask

  initial begin
    #2;
    outs_zero("rst_init");
    tick();
    Reset_n = 1'b1;
    tick();

    // Mid-stream reset: clears RAM and discards the in-flight lookup.
    wr(4'd4, 4'd0, 12'hFFF);
    pix_valid_i = 1'b1; pix_bank_i = 4'd4; pix_idx_i = 4'd0;
    tick();
    pix_valid_i = 1'b0;
    Reset_n = 1'b0;
    #2;
    outs_zero("rst_mid");
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    req("rst_clear", 4'd4, 4'd0, 12'h000, 1'b0);
    tick(); tick();

    // Write then read with latency probe.
    wr(4'd4, 4'd1, 12'h0A5);
    req("wr_rd", 4'd4, 4'd1, 12'h0A5, 1'b0);
    check("lat_n1_valid", {31'd0, pix_valid_o}, 32'd0);
    tick();
    check("lat_n2_valid", {31'd0, pix_valid_o}, 32'd1);
    req("bad_bank", 4'd12, 4'd1, 12'h000, 1'b0);
    wr(4'd12, 4'd1, 12'h777);
    req("bad_bank_wr", 4'd12, 4'd1, 12'h000, 1'b0);
    tick(); tick();

    // Read-first collision.
    wr_en = 1'b1; wr_bank = 4'd2; wr_idx = 4'd3; wr_data = 12'hFFF;
    req("coll_old", 4'd2, 4'd3, 12'h000, 1'b0);
    wr_en = 1'b0;
    req("coll_new", 4'd2, 4'd3, 12'hFFF, 1'b0);
    tick(); tick();

    // Fade.
    wr(4'd5, 4'd2, 12'hFFF);
    bright_i = 4'hF; req("fade_f", 4'd5, 4'd2, 12'hFFF, 1'b0); tick(); tick();
    bright_i = 4'h7; req("fade_7", 4'd5, 4'd2, 12'h777, 1'b0); tick(); tick();
    bright_i = 4'h7; req("fade_7_a5", 4'd4, 4'd1, 12'h052, 1'b0); tick(); tick();
    bright_i = 4'h0; req("fade_0", 4'd5, 4'd2, 12'h000, 1'b0); tick(); tick();
    bright_i = 4'hF;

    // Transparency.
    wr(4'd3, 4'd0, 12'h123);
    transp_en_i = 1'b1; req("transp_on", 4'd3, 4'd0, 12'h123, 1'b1); tick(); tick();
    transp_en_i = 1'b0; req("transp_off", 4'd3, 4'd0, 12'h123, 1'b0); tick(); tick();
    transp_en_i = 1'b1; req("transp_idx1", 4'd4, 4'd1, 12'h0A5, 1'b0); tick(); tick();
    transp_en_i = 1'b0;

    // Flash with FLASH_FRAMES=2; the tick on enable counts as the first.
    flash_en_i = 1'b1; frame_tick_i = 1'b1;
    tick();
    check("flash_tick1", {31'd0, flash_phase_o}, 32'd0);
    tick();
    check("flash_tick2", {31'd0, flash_phase_o}, 32'd1);
    frame_tick_i = 1'b0;
    req("flash_inv", 4'd4, 4'd1, 12'hF5A, 1'b0);
    tick(); tick();
    check("flash_hold", {31'd0, flash_phase_o}, 32'd1);
    frame_tick_i = 1'b1;
    tick();
    frame_tick_i = 1'b0;
    check("flash_tick3", {31'd0, flash_phase_o}, 32'd1);
    flash_en_i = 1'b0;
    tick();
    check("flash_off", {31'd0, flash_phase_o}, 32'd0);
    req("flash_off_rd", 4'd4, 4'd1, 12'h0A5, 1'b0);

    repeat (4) tick();
    check("queue_empty", 32'(q.size()), 32'd0);
    check("pop_count", 32'(n_pop), 32'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
